// File: rtl/hdmi_pll_ctrl.sv
// hdmi_pll_ctrl: reset/lock sequencer for the HDMI pixel-clock PLL (runs on the PLL reference clock).
// Latency: lock rise -> ready in LOCK_STABLE+3 clks; lock loss in RUN -> ready low / pll_reset high in 3 clks.
// Backpressure: none; pll_lock is sampled every clock and restart takes effect on the next edge.
//
// Ports:
//   clk, rst_n   : reference clock, asynchronous active-low reset
//   pll_lock     : raw PLL LOCK (asynchronous), 2-FF synchronized internally
//   restart      : one-cycle synchronous restart request (highest priority)
//   pll_reset    : active-high PLL reset (RESET or FAIL)
//   vid_rst_n    : active-low downstream video reset, released only in RUN
//   ready        : PLL locked and stable (RUN)
//   fail         : retry limit reached (FAIL)
//   retry_cnt    : consecutive lock timeouts, saturating at 15
//   state        : current FSM state for debug
//
// Optional feature: define HDMI_PLL_CTRL_RETRY_LIMIT_EN to enter a terminal FAIL state after
// MAX_RETRY consecutive timeouts. Without it, retries continue forever and fail is tied low.
module hdmi_pll_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       vid_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
  localparam logic [2:0] ST_FAIL      = 3'd4;
  localparam logic [3:0] RETRY_LIM    = 4'(MAX_RETRY);
`endif

  // Terminal counts: a phase of N clocks ends when cnt reaches N-1.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);

  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       state_nxt;
  logic [3:0]       retry_nxt;
  logic [3:0]       retry_inc;
  logic             cnt_clr;
  logic             cnt_run;

`ifndef HDMI_PLL_CTRL_RETRY_LIMIT_EN
  // The retry limit only exists in the FAIL-enabled build.
  logic unused_max_retry;
  assign unused_max_retry = ^(4'(MAX_RETRY));
`endif

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign retry_inc = (retry_cnt == 4'd15) ? 4'd15 : (retry_cnt + 4'd1);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (restart) begin
      state_nxt = ST_RESET;
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
      if (state == ST_FAIL) retry_nxt = 4'd0;
`endif
    end else begin
      case (state)
        ST_RESET: begin
          if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle wins: no retry is charged.
          if (lock_s) begin
            state_nxt = ST_STABLE;
          end else if (cnt == TO_LAST) begin
            retry_nxt = retry_inc;
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
            state_nxt = (retry_inc >= RETRY_LIM) ? ST_FAIL : ST_RESET;
`else
            state_nxt = ST_RESET;
`endif
          end
        end
        ST_STABLE: begin
          // Lock loss on the terminal-count cycle still falls back to WAIT_LOCK.
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
          end else if (cnt == STB_LAST) begin
            state_nxt = ST_RUN;
            retry_nxt = 4'd0;
          end
        end
        ST_RUN: begin
          if (!lock_s) state_nxt = ST_RESET;
        end
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
`endif
        default: begin
          state_nxt = ST_RESET;
        end
      endcase
    end
  end

  // restart also pins cnt at 0 while held, even though the state stays RESET.
  assign cnt_clr = restart || (state_nxt != state);
  // RUN and FAIL have no timed exit, so the counter is frozen there.
  assign cnt_run = (state == ST_RESET) || (state == ST_WAIT_LOCK) || (state == ST_STABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      cnt       <= '0;
      retry_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs decode only the registered state.
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
  assign pll_reset = (state == ST_RESET) || (state == ST_FAIL);
  assign fail      = (state == ST_FAIL);
`else
  assign pll_reset = (state == ST_RESET);
  assign fail      = 1'b0;
`endif
  assign ready     = (state == ST_RUN);
  assign vid_rst_n = (state == ST_RUN);

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// tb_hdmi_pll_ctrl: scoreboard bench for hdmi_pll_ctrl with a behavioural lock-sequencer model.
// Latency: expectations are queued before each edge and compared just after it.
// Backpressure: none; the monitor checks every edge that has a queued expectation.
module tb_hdmi_pll_ctrl;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 3;
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       vrn;
    logic       rdy;
    logic       fl;
    logic [3:0] rc;
  } obs_t;

  localparam obs_t RST_OBS = '{st: 3'd0, prst: 1'b1, vrn: 1'b0, rdy: 1'b0, fl: 1'b0, rc: 4'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic       vid_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  hdmi_pll_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .vid_rst_n(vid_rst_n),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  // Reference model: phase, edges spent in the phase, timeout tally, and
  // the raw lock samples still travelling through the synchronizer.
  int   m_phase;
  int   m_dwell;
  int   m_retry;
  logic m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = P_RESET;
    m_dwell = 0;
    m_retry = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic rn, input logic lk, input logic rs);
    logic ls;
    int   next_ph;
    if (!rn) begin
      m_reset();
      return;
    end
    ls = m_hist.pop_front();  // lock as seen by the FSM: sampled two edges ago
    m_hist.push_back(lk);
    next_ph = m_phase;
    if (rs) begin
      if (m_phase == P_FAIL) m_retry = 0;
      next_ph = P_RESET;
    end else begin
      case (m_phase)
        P_RESET:  if (m_dwell == RST_CYCLES - 1) next_ph = P_WAIT;
        P_WAIT: begin
          if (ls) next_ph = P_STABLE;
          else if (m_dwell == LOCK_TIMEOUT - 1) begin
            m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
            next_ph = (LIMIT_EN && m_retry >= MAX_RETRY) ? P_FAIL : P_RESET;
          end
        end
        P_STABLE: begin
          if (!ls) next_ph = P_WAIT;
          else if (m_dwell == LOCK_STABLE - 1) begin
            next_ph = P_RUN;
            m_retry = 0;
          end
        end
        P_RUN:    if (!ls) next_ph = P_RESET;
        default:  next_ph = m_phase;
      endcase
    end
    m_dwell = (rs || next_ph != m_phase) ? 0 : m_dwell + 1;
    m_phase = next_ph;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.st   = 3'(m_phase);
    o.prst = (m_phase == P_RESET) || (m_phase == P_FAIL);
    o.vrn  = (m_phase == P_RUN);
    o.rdy  = (m_phase == P_RUN);
    o.fl   = (m_phase == P_FAIL);
    o.rc   = 4'(m_retry);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.st   = state;
    o.prst = pll_reset;
    o.vrn  = vid_rst_n;
    o.rdy  = ready;
    o.fl   = fail;
    o.rc   = retry_cnt;
    return o;
  endfunction

  // One clock: drive at the falling edge, queue the expectation, and return
  // just after the rising edge (after the monitor has compared).
  task automatic cyc(input logic rn, input logic lk, input logic rs);
    @(negedge clk);
    rst_n    = rn;
    pll_lock = lk;
    restart  = rs;
    model_edge(rn, lk, rs);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int ph, input int dw, input logic lk, input int maxc, input string nm);
    int n;
    n = 0;
    while (!(m_phase == ph && m_dwell == dw) && n < maxc) begin
      cyc(1'b1, lk, 1'b0);
      n++;
    end
    check(nm, 32'(state), 32'(ph));
  endtask

  // Monitor: compare every edge that has a queued expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_obs();
        check($sformatf("edge%0d {st,prst,vrn,rdy,fl,rc}", edge_n), 32'(a), 32'(e));
      end
    end
  end

  initial begin
    int   fall_k;
    int   rdy_k;
    int   len;
    logic lk;

    m_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Power-up: lock rises 10 edges after pll_reset falls.
    fall_k = 0;
    rdy_k  = 0;
    for (int k = 1; k <= 45; k++) begin
      cyc(1'b1, (k >= 27), 1'b0);
      if (fall_k == 0 && !pll_reset) fall_k = k;
      if (rdy_k == 0 && ready) rdy_k = k;
    end
    check("pwrup_reset_edges", fall_k, 16);
    check("pwrup_lock_to_ready", rdy_k - 26, 11);
    check("pwrup_retry", 32'(retry_cnt), 0);

    // Lock loss in RUN.
    fall_k = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (fall_k == 0 && !ready) fall_k = k;
    end
    check("runloss_edges", fall_k, 3);

    // One-cycle glitch early in STABLE.
    run_until(P_STABLE, 1, 1'b1, 60, "reach_stable");
    cyc(1'b1, 1'b0, 1'b0);
    rdy_k = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (rdy_k == 0 && ready) rdy_k = k;
    end
    check("glitch_return_to_ready", rdy_k, 11);

    // Persistent lock absence: FAIL with the limit, endless retries without.
    for (int k = 0; k < 1500; k++) cyc(1'b1, 1'b0, 1'b0);
    check("tmo_fail", 32'(fail), 32'(LIMIT_EN));
    check("tmo_retry", 32'(retry_cnt), LIMIT_EN ? 3 : 15);

    // Restart out of FAIL / retry loop, held restart, then restart in RUN.
    cyc(1'b1, 1'b0, 1'b1);
    check("restart_state", 32'(state), 0);
    check("restart_pll_reset", 32'(pll_reset), 1);
    check("restart_fail", 32'(fail), 0);
    check("restart_retry", 32'(retry_cnt), LIMIT_EN ? 0 : 15);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    run_until(P_RUN, 0, 1'b1, 200, "reach_run");
    cyc(1'b1, 1'b1, 1'b1);
    check("restart_run_state", 32'(state), 0);
    check("restart_run_ready", 32'(ready), 0);

    // Randomized lock segments with occasional restart pulses.
    for (int s = 0; s < 150; s++) begin
      len = $urandom_range(1, 90);
      lk  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < len; k++) cyc(1'b1, lk, ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset in the middle of STABLE.
    cyc(1'b1, 1'b1, 1'b1);
    run_until(P_STABLE, 3, 1'b1, 300, "reach_stable2");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'(dut_obs()), 32'(RST_OBS));
    m_reset();
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 1'b0);
    check("post_rst_ready", 32'(ready), 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
